// File: rtl/alu_div_seq.sv
// Sequential restoring divider that borrows the shared datapath ALU for every subtract.
// Optional signed support is enabled with `define ALU_DIV_SIGNED_EN (adds the is_signed port).
module alu_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [2:0]   alu_control,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  input  logic [W-1:0] alu_out,
  input  logic         alu_N,
  input  logic         alu_Z,
  input  logic         alu_C,
  input  logic         alu_V
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NEG  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZCHK = 3'd1,
    S_ITER = 3'd2,
    S_DONE = 3'd3,
    S_NEGA = 3'd4,
    S_NEGB = 3'd5,
    S_FIXQ = 3'd6,
    S_FIXR = 3'd7
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_r, r_q, r_d;
  logic [W-1:0]  w_r_nxt, w_q_nxt, w_d_nxt, w_shift;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, r_done, r_dz;
  logic          w_busy_nxt, w_done_nxt, w_dz_nxt;
  logic [W-1:0]  r_quot, r_rem, w_quot_nxt, w_rem_nxt;
  logic [2:0]    r_alu_ctl, w_alu_ctl_nxt;
  logic [W-1:0]  r_alu_a, r_alu_b, w_alu_a_nxt, w_alu_b_nxt;
  logic          w_unused_flags;
`ifdef ALU_DIV_SIGNED_EN
  logic          r_sgn, r_sa, r_sb;
  logic          w_sgn_nxt, w_sa_nxt, w_sb_nxt;
`endif

  assign w_shift        = {r_r[W-2:0], r_q[W-1]};
  assign w_unused_flags = ^{alu_N, alu_Z, alu_V};

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;
  assign alu_control = r_alu_ctl;
  assign alu_A       = r_alu_a;
  assign alu_B       = r_alu_b;

  // Next-state and datapath update; results are captured on the edge entering DONE
  always_comb begin
    w_state_nxt = r_state;
    w_r_nxt     = r_r;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_dz_nxt    = r_dz;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;
`ifdef ALU_DIV_SIGNED_EN
    w_sgn_nxt   = r_sgn;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_q_nxt     = dividend;
          w_d_nxt     = divisor;
          w_r_nxt     = {W{1'b0}};
          w_cnt_nxt   = CW'(W - 1);
`ifdef ALU_DIV_SIGNED_EN
          w_sgn_nxt   = is_signed;
          w_sa_nxt    = is_signed & dividend[W-1];
          w_sb_nxt    = is_signed & divisor[W-1];
`endif
          w_state_nxt = S_ZCHK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ZCHK: begin
        if (r_d == {W{1'b0}}) begin
          w_quot_nxt  = {W{1'b1}};
          w_rem_nxt   = r_q;
          w_dz_nxt    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_dz_nxt    = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
          w_state_nxt = r_sgn ? S_NEGA : S_ITER;
`else
          w_state_nxt = S_ITER;
`endif
        end
      end
      S_ITER: begin
        // alu_C high means no borrow: the trial subtract is kept
        if (alu_C) begin
          w_r_nxt = alu_out;
          w_q_nxt = {r_q[W-2:0], 1'b1};
        end else begin
          w_r_nxt = w_shift;
          w_q_nxt = {r_q[W-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == {CW{1'b0}}) begin
`ifdef ALU_DIV_SIGNED_EN
          if (r_sgn) begin
            w_state_nxt = S_FIXQ;
          end else begin
            w_quot_nxt  = w_q_nxt;
            w_rem_nxt   = w_r_nxt;
            w_state_nxt = S_DONE;
          end
`else
          w_quot_nxt  = w_q_nxt;
          w_rem_nxt   = w_r_nxt;
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_ITER;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
`ifdef ALU_DIV_SIGNED_EN
      S_NEGA: begin
        if (r_sa) begin
          w_q_nxt = alu_out;
        end else begin
          w_q_nxt = r_q;
        end
        w_state_nxt = S_NEGB;
      end
      S_NEGB: begin
        if (r_sb) begin
          w_d_nxt = alu_out;
        end else begin
          w_d_nxt = r_d;
        end
        w_state_nxt = S_ITER;
      end
      S_FIXQ: begin
        if (r_sa ^ r_sb) begin
          w_q_nxt = alu_out;
        end else begin
          w_q_nxt = r_q;
        end
        w_state_nxt = S_FIXR;
      end
      S_FIXR: begin
        // remainder follows the dividend's sign
        if (r_sa) begin
          w_r_nxt = alu_out;
        end else begin
          w_r_nxt = r_r;
        end
        w_quot_nxt  = w_q_nxt;
        w_rem_nxt   = w_r_nxt;
        w_state_nxt = S_DONE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ALU request and status for the upcoming state, so the registered outputs line up with it
  always_comb begin
    w_alu_ctl_nxt = OP_NONE;
    w_alu_a_nxt   = {W{1'b0}};
    w_alu_b_nxt   = {W{1'b0}};
    w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    case (w_state_nxt)
      S_ITER: begin
        w_alu_ctl_nxt = OP_SUB;
        w_alu_a_nxt   = {w_r_nxt[W-2:0], w_q_nxt[W-1]};
        w_alu_b_nxt   = w_d_nxt;
      end
`ifdef ALU_DIV_SIGNED_EN
      S_NEGA, S_FIXQ: begin
        w_alu_ctl_nxt = OP_NEG;
        w_alu_a_nxt   = w_q_nxt;
      end
      S_NEGB: begin
        w_alu_ctl_nxt = OP_NEG;
        w_alu_a_nxt   = w_d_nxt;
      end
      S_FIXR: begin
        w_alu_ctl_nxt = OP_NEG;
        w_alu_a_nxt   = w_r_nxt;
      end
`endif
      default: begin
        w_alu_ctl_nxt = OP_NONE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r       <= {W{1'b0}};
      r_q       <= {W{1'b0}};
      r_d       <= {W{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_quot    <= {W{1'b0}};
      r_rem     <= {W{1'b0}};
      r_alu_ctl <= OP_NONE;
      r_alu_a   <= {W{1'b0}};
      r_alu_b   <= {W{1'b0}};
`ifdef ALU_DIV_SIGNED_EN
      r_sgn     <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
`endif
    end else begin
      r_r       <= w_r_nxt;
      r_q       <= w_q_nxt;
      r_d       <= w_d_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dz      <= w_dz_nxt;
      r_quot    <= w_quot_nxt;
      r_rem     <= w_rem_nxt;
      r_alu_ctl <= w_alu_ctl_nxt;
      r_alu_a   <= w_alu_a_nxt;
      r_alu_b   <= w_alu_b_nxt;
`ifdef ALU_DIV_SIGNED_EN
      r_sgn     <= w_sgn_nxt;
      r_sa      <= w_sa_nxt;
      r_sb      <= w_sb_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq at W=8 with a behavioural combinational ALU beside it.
module tb_alu_div_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = 8'd0;
  logic [W-1:0] divisor = 8'd0;
  logic         is_signed_v = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_A, alu_B, alu_out;
  logic         alu_N, alu_Z, alu_C, alu_V;

  int checks = 0;
  int failures = 0;
  int cyc;
  int done_cyc;
  logic done_seen;

  always #5 clk = ~clk;

  alu_div_seq #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef ALU_DIV_SIGNED_EN
    .is_signed(is_signed_v),
`endif
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .alu_control(alu_control),
    .alu_A(alu_A),
    .alu_B(alu_B),
    .alu_out(alu_out),
    .alu_N(alu_N),
    .alu_Z(alu_Z),
    .alu_C(alu_C),
    .alu_V(alu_V)
  );

  // Shared ALU: op 0 add, op 1 A-B with carry = no borrow, op 2 negate A
  always_comb begin
    alu_out = 8'd0;
    alu_C   = 1'b0;
    alu_V   = 1'b0;
    case (alu_control)
      3'd0: alu_out = alu_A + alu_B;
      3'd1: begin
        alu_out = alu_A - alu_B;
        alu_C   = (alu_A >= alu_B);
      end
      3'd2: alu_out = 8'd0 - alu_A;
      default: alu_out = 8'd0;
    endcase
    alu_N = alu_out[W-1];
    alu_Z = (alu_out == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {8'd0, busy, done, div_by_zero, alu_control, quotient},
        32'd0);
    chk({tag, "_data"}, {8'd0, remainder, alu_A, alu_B}, 32'd0);
  endtask

  // Present operands in cycle 0, then follow the operation until done (bounded)
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sgn, input int exp_cyc, input logic [7:0] eq,
                         input logic [7:0] er, input logic edz, input logic hold);
    int   dc;
    int   c;
    logic busy_bad;
    logic saw_sub;
    dividend    = a;
    divisor     = b;
    is_signed_v = sgn;
    start       = 1'b1;
    dc          = -1;
    c           = 0;
    busy_bad    = 1'b0;
    saw_sub     = 1'b0;
    while (dc < 0 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (hold) begin
        dividend = 8'hA5;
        divisor  = 8'h03;
      end else begin
        start = 1'b0;
      end
      if (alu_control == 3'd1) saw_sub = 1'b1;
      if (done === 1'b1) dc = c;
      if (busy !== (c < exp_cyc)) busy_bad = 1'b1;
    end
    chk({tag, "_latency"}, dc, exp_cyc);
    chk({tag, "_busy"}, busy_bad, 32'd0);
    chk({tag, "_alu_sub_used"}, saw_sub, (b != 8'd0));
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_by_zero"}, div_by_zero, edz);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {busy, done}, 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 1'b0, 10, 8'd14, 8'd2, 1'b0, 1'b0);
    run_div("d255_200", 8'd255, 8'd200, 1'b0, 10, 8'd1, 8'd55, 1'b0, 1'b0);
    run_div("d42_0", 8'd42, 8'd0, 1'b0, 2, 8'd255, 8'd42, 1'b1, 1'b0);
    run_div("d0_5", 8'd0, 8'd5, 1'b0, 10, 8'd0, 8'd0, 1'b0, 1'b0);
    run_div("d77_77", 8'd77, 8'd77, 1'b0, 10, 8'd1, 8'd0, 1'b0, 1'b0);

    // start stays high with different operands through busy and DONE
    run_div("hold", 8'd200, 8'd9, 1'b0, 10, 8'd22, 8'd2, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("b2b_busy", busy, 32'd1);
    start    = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) done_cyc = cyc;
    end
    chk("b2b_latency", done_cyc, 32'd10);
    chk("b2b_quotient", quotient, 32'd55);
    chk("b2b_remainder", remainder, 32'd0);
    @(posedge clk);
    #1;

    // abort in the fourth ITER cycle
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 32'd0);
    rst_n = 1'b1;
    #1;
    run_div("d9_3", 8'd9, 8'd3, 1'b0, 10, 8'd3, 8'd0, 1'b0, 1'b0);

`ifdef ALU_DIV_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 1'b1, 14, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_div("s_min_m1", 8'h80, 8'hFF, 1'b1, 14, 8'h80, 8'h00, 1'b0, 1'b0);
    run_div("s_100_m7", 8'd100, 8'hF9, 1'b1, 14, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_div("s_div0", 8'h9C, 8'd0, 1'b1, 2, 8'hFF, 8'h9C, 1'b1, 1'b0);
    run_div("u_156_7", 8'h9C, 8'd7, 1'b0, 10, 8'd22, 8'd2, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
